// File: rtl/umi_pipe.sv
// umi_pipe: registered two-entry UMI skid buffer.
// Every handshake output (ready, valid, payload) comes straight from a flop.
// This breaks all combinational paths, including the ready path.
// It still sustains one transaction per cycle.
// Optional feature macro: UMI_PIPE_STATS_EN adds handshake/stall counters.
module umi_pipe #(
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 128,
  parameter int unsigned SW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready
`ifdef UMI_PIPE_STATS_EN
  ,
  input  logic          stats_clear,
  output logic [SW-1:0] txn_count,
  output logic [SW-1:0] stall_count
`endif
);

  // Counter width must be usable even when the counters are compiled out.
  if (SW < 1) begin : g_bad_sw
    $error("umi_pipe: SW must be at least 1");
  end

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t   state_q, state_d;
  payload_t out_q, skid_q, in_pl;
  logic     in_ready_q, out_valid_q;
  logic     in_fire, out_fire;
  logic     out_load_in, out_load_skid, skid_load;

  assign in_pl    = '{cmd: umi_in_cmd, dstaddr: umi_in_dstaddr,
                      srcaddr: umi_in_srcaddr, data: umi_in_data};
  assign in_fire  = umi_in_valid & in_ready_q;
  assign out_fire = out_valid_q & umi_out_ready;

  // Next-state and register-load decode.
  always_comb begin
    state_d       = state_q;
    out_load_in   = 1'b0;
    out_load_skid = 1'b0;
    skid_load     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = ONE;
          out_load_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          out_load_in = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Ready is low in FULL, so no input can arrive here.
        if (out_fire) begin
          state_d       = ONE;
          out_load_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, handshake flags and payload registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (out_load_in) begin
        out_q <= in_pl;
      end else if (out_load_skid) begin
        out_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_pl;
      end
    end
  end

  assign umi_in_ready    = in_ready_q;
  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = out_q.cmd;
  assign umi_out_dstaddr = out_q.dstaddr;
  assign umi_out_srcaddr = out_q.srcaddr;
  assign umi_out_data    = out_q.data;

`ifdef UMI_PIPE_STATS_EN
  logic [SW-1:0] txn_q, stall_q;
  logic          stall;

  assign stall = out_valid_q & ~umi_out_ready;

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      txn_q   <= '0;
      stall_q <= '0;
    end else if (stats_clear) begin
      txn_q   <= '0;
      stall_q <= '0;
    end else begin
      if (out_fire && (txn_q != {SW{1'b1}})) begin
        txn_q <= txn_q + SW'(1);
      end
      if (stall && (stall_q != {SW{1'b1}})) begin
        stall_q <= stall_q + SW'(1);
      end
    end
  end

  assign txn_count   = txn_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_umi_pipe.sv
// Directed bench for umi_pipe.
// Inputs are driven on the falling edge.
// Outputs are checked on the falling edge, before new inputs are applied.
module tb_umi_pipe;

  localparam int unsigned CW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 128;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic          umi_in_valid;
  logic [CW-1:0] umi_in_cmd;
  logic [AW-1:0] umi_in_dstaddr;
  logic [AW-1:0] umi_in_srcaddr;
  logic [DW-1:0] umi_in_data;
  logic          umi_in_ready;
  logic          umi_out_valid;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          umi_out_ready;
`ifdef UMI_PIPE_STATS_EN
  logic          stats_clear;
  logic [SW-1:0] txn_count;
  logic [SW-1:0] stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  umi_pipe #(.CW(CW), .AW(AW), .DW(DW), .SW(SW)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .umi_in_valid   (umi_in_valid),
    .umi_in_cmd     (umi_in_cmd),
    .umi_in_dstaddr (umi_in_dstaddr),
    .umi_in_srcaddr (umi_in_srcaddr),
    .umi_in_data    (umi_in_data),
    .umi_in_ready   (umi_in_ready),
    .umi_out_valid  (umi_out_valid),
    .umi_out_cmd    (umi_out_cmd),
    .umi_out_dstaddr(umi_out_dstaddr),
    .umi_out_srcaddr(umi_out_srcaddr),
    .umi_out_data   (umi_out_data),
    .umi_out_ready  (umi_out_ready)
`ifdef UMI_PIPE_STATS_EN
    ,
    .stats_clear    (stats_clear),
    .txn_count      (txn_count),
    .stall_count    (stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [AW-1:0] d,
                       input logic [AW-1:0] s, input logic [DW-1:0] dat);
    umi_in_valid   = v;
    umi_in_cmd     = c;
    umi_in_dstaddr = d;
    umi_in_srcaddr = s;
    umi_in_data    = dat;
  endtask

  initial begin
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    nreset = 1'b0;
    umi_out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
`ifdef UMI_PIPE_STATS_EN
    stats_clear = 1'b0;
`endif

    // Reset state
    #1;
    chk("rst_in_ready", 128'(umi_in_ready), 128'(0));
    chk("rst_out_valid", 128'(umi_out_valid), 128'(0));
    chk("rst_out_data", 128'(umi_out_data), 128'(0));
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    chk("rel_in_ready_pre_edge", 128'(umi_in_ready), 128'(0));
    @(negedge clk);
    chk("rel_in_ready_post_edge", 128'(umi_in_ready), 128'(1));

    // Single beat
    umi_out_ready = 1'b1;
    drive(1'b1, 32'h5, 64'h1000, 64'h2000, a5);
    @(negedge clk);
    chk("single_valid", 128'(umi_out_valid), 128'(1));
    chk("single_cmd", 128'(umi_out_cmd), 128'(32'h5));
    chk("single_dst", 128'(umi_out_dstaddr), 128'(64'h1000));
    chk("single_src", 128'(umi_out_srcaddr), 128'(64'h2000));
    chk("single_data", 128'(umi_out_data), 128'(a5));
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    chk("single_gone", 128'(umi_out_valid), 128'(0));

    // Streaming: 8 beats, in ONE with simultaneous in/out fire each edge
    drive(1'b1, 32'h11, 64'h0, 64'h0, 128'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", 128'(umi_out_valid), 128'(1));
      chk("stream_data", 128'(umi_out_data), 128'(i));
      chk("stream_ready", 128'(umi_in_ready), 128'(1));
      if (i < 7) drive(1'b1, 32'h11, 64'h0, 64'h0, 128'(i + 1));
      else       drive(1'b0, '0, '0, '0, '0);
    end
    @(negedge clk);
    chk("stream_drained", 128'(umi_out_valid), 128'(0));

    // Backpressure: three beats offered with downstream stalled
    umi_out_ready = 1'b0;
    drive(1'b1, 32'h22, 64'h0, 64'h0, 128'(0));
    @(negedge clk);
    chk("bp_one_data", 128'(umi_out_data), 128'(0));
    chk("bp_one_ready", 128'(umi_in_ready), 128'(1));
    drive(1'b1, 32'h22, 64'h0, 64'h0, 128'(1));
    @(negedge clk);
    chk("bp_full_ready", 128'(umi_in_ready), 128'(0));
    chk("bp_full_data", 128'(umi_out_data), 128'(0));
    drive(1'b1, 32'h22, 64'h0, 64'h0, 128'(2));
    @(negedge clk);
    chk("bp_hold_ready", 128'(umi_in_ready), 128'(0));
    chk("bp_hold_data", 128'(umi_out_data), 128'(0));
    chk("bp_hold_valid", 128'(umi_out_valid), 128'(1));
    umi_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain1_data", 128'(umi_out_data), 128'(1));
    chk("bp_drain1_ready", 128'(umi_in_ready), 128'(1));
    @(negedge clk);
    chk("bp_drain2_data", 128'(umi_out_data), 128'(2));
    chk("bp_drain2_valid", 128'(umi_out_valid), 128'(1));
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    chk("bp_empty", 128'(umi_out_valid), 128'(0));

    // Async reset while FULL
    umi_out_ready = 1'b0;
    drive(1'b1, 32'h33, 64'h44, 64'h55, 128'hAA);
    @(negedge clk);
    drive(1'b1, 32'h33, 64'h44, 64'h55, 128'hBB);
    @(negedge clk);
    chk("pre_rst_full", 128'(umi_in_ready), 128'(0));
    #2 nreset = 1'b0;
    #1;
    chk("arst_out_valid", 128'(umi_out_valid), 128'(0));
    chk("arst_in_ready", 128'(umi_in_ready), 128'(0));
    chk("arst_data", 128'(umi_out_data), 128'(0));
    chk("arst_cmd", 128'(umi_out_cmd), 128'(0));
    chk("arst_dst", 128'(umi_out_dstaddr), 128'(0));
    drive(1'b0, '0, '0, '0, '0);
    umi_out_ready = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 128'(umi_in_ready), 128'(1));
    chk("post_rst_no_stale0", 128'(umi_out_valid), 128'(0));
    @(negedge clk);
    chk("post_rst_no_stale1", 128'(umi_out_valid), 128'(0));

`ifdef UMI_PIPE_STATS_EN
    // Statistics counters
    chk("stats_rst_txn", 128'(txn_count), 128'(0));
    chk("stats_rst_stall", 128'(stall_count), 128'(0));
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h66, 64'h0, 64'h0, 128'(i));
      @(negedge clk);
    end
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    chk("stats_txn_sat", 128'(txn_count), 128'(15));
    chk("stats_no_stall", 128'(stall_count), 128'(0));
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    chk("stats_cleared", 128'(txn_count), 128'(0));
    umi_out_ready = 1'b0;
    drive(1'b1, 32'h77, 64'h0, 64'h0, 128'h1);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("stats_stall3", 128'(stall_count), 128'(3));
    umi_out_ready = 1'b1;
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    chk("stats_clr_txn", 128'(txn_count), 128'(0));
    chk("stats_clr_stall", 128'(stall_count), 128'(0));
    chk("stats_clr_fired", 128'(umi_out_valid), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/umi_pipe.md
# umi_pipe

Registered UMI pipeline stage (two-entry skid buffer) placed between a `umi_fifo` output and a UMI device port such as `umi_mem_agent`'s request input. It cuts every combinational path of the valid/ready handshake, including the ready path, while sustaining one transaction per cycle. Transaction order and contents are preserved unchanged.

## Interface
Parameters:
- CW, 32, command width
- AW, 64, address width
- DW, 128, data width
- SW, 32, statistics counter width (used only with UMI_PIPE_STATS_EN)

Ports:
- clk  input  1  clock; all logic on rising edge
- nreset  input  1  reset; asynchronous, active-low
- umi_in_valid  input  1  upstream transaction valid
- umi_in_cmd / umi_in_dstaddr / umi_in_srcaddr / umi_in_data  input  CW / AW / AW / DW  upstream payload
- umi_in_ready  output  1  stage can accept; driven directly from a flop
- umi_out_valid  output  1  downstream transaction valid; driven directly from a flop
- umi_out_cmd / umi_out_dstaddr / umi_out_srcaddr / umi_out_data  output  CW / AW / AW / DW  downstream payload; driven directly from flops
- umi_out_ready  input  1  downstream accepts
- stats_clear  input  1  synchronous clear of counters (UMI_PIPE_STATS_EN only)
- txn_count  output  SW  completed output handshakes (UMI_PIPE_STATS_EN only)
- stall_count  output  SW  cycles with umi_out_valid=1 and umi_out_ready=0 (UMI_PIPE_STATS_EN only)

## Operation
- Handshake definitions:
  - in_fire = umi_in_valid & umi_in_ready.
  - out_fire = umi_out_valid & umi_out_ready.
- Storage:
  - Output register (OUT) drives the umi_out_* signals.
  - Skid register (SKID) holds one extra transaction.
- FSM states:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- Transitions:
  - EMPTY, in_fire → ONE; OUT loads input.
  - ONE, in_fire & out_fire → ONE; OUT loads input.
  - ONE, in_fire & !out_fire → FULL; SKID loads input.
  - ONE, !in_fire & out_fire → EMPTY.
  - FULL, out_fire → ONE; OUT loads SKID. in_fire is impossible in FULL.
  - All other cases: hold state and contents.
- umi_in_ready register next value = (next_state != FULL).
- umi_out_valid = (state != EMPTY).
- Payload is passed bit-exact. The block does not decode cmd.
- Inputs are ignored when umi_in_valid=0. The held payload does not change while umi_out_valid=1 and umi_out_ready=0.

## Timing
- Latency: a transaction accepted at edge N (state EMPTY, or ONE with simultaneous out_fire) is presented on umi_out_* in the cycle after edge N.
- Throughput: one transaction per cycle while umi_out_ready=1.
- Backpressure:
  - umi_in_ready falls in the cycle after the edge that enters FULL.
  - umi_in_ready rises in the cycle after the edge that leaves FULL.
  - No transaction is dropped, because SKID absorbs the in-flight beat.
- Reset (asynchronous assert, any time including mid-transfer):
  - state=EMPTY.
  - umi_in_ready=0, umi_out_valid=0.
  - All payload outputs 0.
  - Counters 0.
  - In-flight transactions are discarded.
  - umi_in_ready becomes 1 at the first rising edge after nreset deasserts.
- No combinational path exists from any input to any output.

## Configuration
- UMI_PIPE_STATS_EN defined:
  - stats_clear, txn_count and stall_count ports exist.
  - txn_count increments on each out_fire.
  - stall_count increments on each cycle with umi_out_valid & !umi_out_ready.
  - Both counters saturate at 2^SW−1.
  - stats_clear=1 forces both to 0 at the next edge, and takes priority over a simultaneous increment.
- UMI_PIPE_STATS_EN undefined: the three ports and all counter logic are absent. Datapath behaviour is identical.

## Test plan
- Single beat: out_ready=1; one beat (cmd=0x5, dstaddr=0x1000, data=0xA5..A5) accepted at edge N → umi_out_valid=1 with identical payload in cycle N+1, umi_out_valid=0 in cycle N+2.
- Streaming: 8 back-to-back beats with data=0..7, out_ready held 1 → umi_in_ready never drops; outputs 0..7 on 8 consecutive cycles.
- Backpressure: out_ready=0, offer 3 beats → first 2 accepted; umi_in_ready=0 from the cycle after the second accept. Raise out_ready → outputs 0,1,2 in order, no loss or duplication.
- Simultaneous events: in state ONE, in_fire and out_fire on the same edge for 5 cycles → state stays ONE and umi_in_ready stays 1.
- Reset mid-operation: assert nreset asynchronously while FULL → umi_out_valid, umi_in_ready and payload are 0 immediately. After release, umi_in_ready=1 after one edge, and no stale beat is emitted.
- Stats (UMI_PIPE_STATS_EN, SW=4): 20 handshakes → txn_count=15 (saturated). 3 stalled cycles → stall_count=3. stats_clear together with an out_fire → both counters 0 on the next cycle.
